// File: rtl/axi_riscv_rsv_pkg.sv
// Shared types for the LR/SC reservation table: the entry record and the
// helper that reduces a byte address to its reservation granule.
package axi_riscv_rsv_pkg;

  // Entries are stored at the widest supported address/ID width. Narrower
  // configurations zero-extend, so comparisons stay exact.
  localparam int unsigned RSV_ADDR_MAX_W = 64;
  localparam int unsigned RSV_ID_MAX_W   = 16;

  typedef logic [RSV_ADDR_MAX_W-1:0] rsv_gran_t;

  typedef struct packed {
    logic                    valid;
    logic [RSV_ID_MAX_W-1:0] id;
    rsv_gran_t               gran;
  } rsv_entry_t;

  function automatic rsv_gran_t rsv_gran_of(input logic [RSV_ADDR_MAX_W-1:0] addr,
                                            input int unsigned gran_log2);
    return addr >> gran_log2;
  endfunction

endpackage

// File: rtl/axi_riscv_rsv_alloc.sv
// Slot allocation for the reservation table: lowest-index free-slot finder
// and the round-robin victim pointer used when the table is full.
module axi_riscv_rsv_alloc #(
  parameter int unsigned NUM_RSV = 4,
  parameter int unsigned IDX_W   = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_RSV-1:0] valid_i,
  input  logic               evict_i,
  output logic               free_o,
  output logic [IDX_W-1:0]   free_idx_o,
  output logic [IDX_W-1:0]   victim_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Lowest-index free slot: scan downwards so the last hit is the lowest.
  always_comb begin
    free_o     = 1'b0;
    free_idx_o = '0;
    for (int i = NUM_RSV - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_o     = 1'b1;
        free_idx_o = IDX_W'(i);
      end
    end
  end

  // Pointer increment wraps at NUM_RSV, which need not be a power of two.
  always_comb begin
    ptr_d = (ptr_q == IDX_W'(NUM_RSV - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Victim pointer advances only when an eviction actually happens.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (evict_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign victim_idx_o = ptr_q;

endmodule

// File: rtl/axi_riscv_rsv_table.sv
// LR/SC reservation table for an AXI RISC-V atomics adapter.
// Same-cycle ordering: SC check on start-of-cycle state, then write/SC
// invalidations, then LR allocation, so an LR always survives.
// Optional macro AXI_RISCV_RSV_STATS_EN enables saturating SC ok/fail counters.
module axi_riscv_rsv_table
  import axi_riscv_rsv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           NUM_RSV    = 4,
  parameter int unsigned           GRAN_LOG2  = 3,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_END   = ADDR_WIDTH'(64'h0000_7fff_ffff_ffff)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lr_valid_i,
  output logic                         lr_ready_o,
  input  logic [ADDR_WIDTH-1:0]        lr_addr_i,
  input  logic [ID_WIDTH-1:0]          lr_id_i,
  input  logic                         sc_valid_i,
  output logic                         sc_ready_o,
  input  logic [ADDR_WIDTH-1:0]        sc_addr_i,
  input  logic [ID_WIDTH-1:0]          sc_id_i,
  output logic                         sc_resp_valid_o,
  input  logic                         sc_resp_ready_i,
  output logic                         sc_resp_ok_o,
  output logic [ID_WIDTH-1:0]          sc_resp_id_o,
  input  logic                         wr_valid_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  output logic [$clog2(NUM_RSV+1)-1:0] rsv_count_o,
  output logic [31:0]                  sc_ok_cnt_o,
  output logic [31:0]                  sc_fail_cnt_o
);

  localparam int unsigned IDX_W = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_RSV + 1);

  rsv_entry_t entry_q [NUM_RSV];
  rsv_entry_t entry_d [NUM_RSV];
  logic [NUM_RSV-1:0] mid_valid;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic                sc_resp_valid_q, sc_resp_ok_q;
  logic [ID_WIDTH-1:0] sc_resp_id_q;

  logic             sc_fire, sc_ok, lr_hit, evict;
  logic             lr_in_range, sc_in_range;
  logic             free;
  logic [IDX_W-1:0] free_idx, victim_idx;

  rsv_gran_t                lr_gran, sc_gran, wr_gran;
  logic [RSV_ID_MAX_W-1:0]  lr_id_x, sc_id_x;

  assign lr_gran = rsv_gran_of(RSV_ADDR_MAX_W'(lr_addr_i), GRAN_LOG2);
  assign sc_gran = rsv_gran_of(RSV_ADDR_MAX_W'(sc_addr_i), GRAN_LOG2);
  assign wr_gran = rsv_gran_of(RSV_ADDR_MAX_W'(wr_addr_i), GRAN_LOG2);
  assign lr_id_x = RSV_ID_MAX_W'(lr_id_i);
  assign sc_id_x = RSV_ID_MAX_W'(sc_id_i);

  // Offset form of the closed-interval check avoids a constant compare at ADDR_BEGIN = 0.
  assign lr_in_range = (lr_addr_i - ADDR_BEGIN) <= (ADDR_END - ADDR_BEGIN);
  assign sc_in_range = (sc_addr_i - ADDR_BEGIN) <= (ADDR_END - ADDR_BEGIN);

  assign lr_ready_o = 1'b1;
  assign sc_ready_o = !sc_resp_valid_q || sc_resp_ready_i;
  assign sc_fire    = sc_valid_i && sc_ready_o;

  // SC outcome against the table as it stood at the start of the cycle.
  always_comb begin
    sc_ok = 1'b0;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (entry_q[i].valid && entry_q[i].id == sc_id_x && entry_q[i].gran == sc_gran) begin
        sc_ok = sc_in_range;
      end
    end
  end

  // Validity after write-snoop and SC invalidations, before any LR.
  always_comb begin
    mid_valid = '0;
    for (int i = 0; i < NUM_RSV; i++) begin
      mid_valid[i] = entry_q[i].valid;
      if (wr_valid_i && entry_q[i].gran == wr_gran)        mid_valid[i] = 1'b0;
      if (sc_fire && entry_q[i].id == sc_id_x)             mid_valid[i] = 1'b0;
      if (sc_fire && sc_ok && entry_q[i].gran == sc_gran)  mid_valid[i] = 1'b0;
    end
  end

  axi_riscv_rsv_alloc #(
    .NUM_RSV (NUM_RSV),
    .IDX_W   (IDX_W)
  ) i_alloc (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (mid_valid),
    .evict_i      (evict),
    .free_o       (free),
    .free_idx_o   (free_idx),
    .victim_idx_o (victim_idx)
  );

  // LR applied last: refresh a same-ID entry, else take a free slot, else evict.
  always_comb begin
    entry_d = entry_q;
    lr_hit  = 1'b0;
    evict   = 1'b0;
    for (int i = 0; i < NUM_RSV; i++) entry_d[i].valid = mid_valid[i];
    if (lr_valid_i && lr_in_range) begin
      for (int i = 0; i < NUM_RSV; i++) begin
        if (mid_valid[i] && entry_q[i].id == lr_id_x) begin
          lr_hit          = 1'b1;
          entry_d[i].gran = lr_gran;
        end
      end
      if (!lr_hit) begin
        evict = !free;
        for (int i = 0; i < NUM_RSV; i++) begin
          if ((free && IDX_W'(i) == free_idx) || (!free && IDX_W'(i) == victim_idx)) begin
            entry_d[i] = '{valid: 1'b1, id: lr_id_x, gran: lr_gran};
          end
        end
      end
    end
  end

  // Population count of the next table for the registered count output.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_RSV; i++) cnt_d = cnt_d + CNT_W'(entry_d[i].valid);
  end

  // Table and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_RSV; i++) entry_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  // SC response register: loaded on accept, held until the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_resp_valid_q <= 1'b0;
      sc_resp_ok_q    <= 1'b0;
      sc_resp_id_q    <= '0;
    end else if (sc_fire) begin
      sc_resp_valid_q <= 1'b1;
      sc_resp_ok_q    <= sc_ok;
      sc_resp_id_q    <= sc_id_i;
    end else if (sc_resp_ready_i) begin
      sc_resp_valid_q <= 1'b0;
    end
  end

  assign sc_resp_valid_o = sc_resp_valid_q;
  assign sc_resp_ok_o    = sc_resp_ok_q;
  assign sc_resp_id_o    = sc_resp_id_q;
  assign rsv_count_o     = cnt_q;

`ifdef AXI_RISCV_RSV_STATS_EN
  logic [31:0] ok_cnt_q, fail_cnt_q;

  // Saturating outcome counters, bumped when a response is handed off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else if (sc_resp_valid_q && sc_resp_ready_i) begin
      if (sc_resp_ok_q) begin
        if (ok_cnt_q != 32'hFFFF_FFFF) ok_cnt_q <= ok_cnt_q + 32'd1;
      end else begin
        if (fail_cnt_q != 32'hFFFF_FFFF) fail_cnt_q <= fail_cnt_q + 32'd1;
      end
    end
  end

  assign sc_ok_cnt_o   = ok_cnt_q;
  assign sc_fail_cnt_o = fail_cnt_q;
`else
  assign sc_ok_cnt_o   = '0;
  assign sc_fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_riscv_rsv_table.sv
// Bench for axi_riscv_rsv_table: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_axi_riscv_rsv_table;

  localparam int          IW    = 4;
  localparam int          NR    = 4;
  localparam int          GL    = 3;
  localparam logic [63:0] A_END = 64'h0000_7fff_ffff_ffff;

  logic          clk_i = 1'b0;
  logic          rst_i, lr_valid_i, lr_ready_o, sc_valid_i, sc_ready_o;
  logic [63:0]   lr_addr_i, sc_addr_i, wr_addr_i;
  logic [IW-1:0] lr_id_i, sc_id_i, sc_resp_id_o;
  logic          sc_resp_valid_o, sc_resp_ready_i, sc_resp_ok_o, wr_valid_i;
  logic [2:0]    rsv_count_o;
  logic [31:0]   sc_ok_cnt_o, sc_fail_cnt_o;

  always #5 clk_i = ~clk_i;

  axi_riscv_rsv_table dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lr_valid_i(lr_valid_i), .lr_ready_o(lr_ready_o), .lr_addr_i(lr_addr_i), .lr_id_i(lr_id_i),
    .sc_valid_i(sc_valid_i), .sc_ready_o(sc_ready_o), .sc_addr_i(sc_addr_i), .sc_id_i(sc_id_i),
    .sc_resp_valid_o(sc_resp_valid_o), .sc_resp_ready_i(sc_resp_ready_i),
    .sc_resp_ok_o(sc_resp_ok_o), .sc_resp_id_o(sc_resp_id_o),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i),
    .rsv_count_o(rsv_count_o), .sc_ok_cnt_o(sc_ok_cnt_o), .sc_fail_cnt_o(sc_fail_cnt_o)
  );

  typedef struct {
    bit rst; bit lrv; logic [63:0] lra; logic [IW-1:0] lrid;
    bit scv; logic [63:0] sca; logic [IW-1:0] scid;
    bit rdy; bit wrv; logic [63:0] wra;
  } stim_t;

  typedef struct {
    stim_t s; bit exp_rv; bit exp_ok; int exp_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: a set of reservations plus the response slot.
  bit            m_v  [NR];
  logic [IW-1:0] m_id [NR];
  logic [63:0]   m_g  [NR];
  int            m_ptr;
  bit            m_rv, m_ok;
  logic [IW-1:0] m_rid;
  logic [31:0]   m_okc, m_failc;
  logic [63:0]   a_begin = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >= a_begin) && (a <= A_END);
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_v[i]);
    return c;
  endfunction

  function automatic stim_t S(bit rst, bit lrv, logic [63:0] lra, int lrid, bit scv,
                              logic [63:0] sca, int scid, bit rdy, bit wrv, logic [63:0] wra);
    stim_t s;
    s.rst = rst; s.lrv = lrv; s.lra = lra; s.lrid = IW'(lrid);
    s.scv = scv; s.sca = sca; s.scid = IW'(scid);
    s.rdy = rdy; s.wrv = wrv; s.wra = wra;
    return s;
  endfunction

  task automatic model_step(input stim_t s);
    bit nv [NR];
    bit fire, ok, hit;
    int slot;
    logic [63:0] sg, wg, lg;
    if (s.rst) begin
      for (int i = 0; i < NR; i++) begin m_v[i] = 0; m_id[i] = '0; m_g[i] = '0; end
      m_ptr = 0; m_rv = 0; m_ok = 0; m_rid = '0; m_okc = '0; m_failc = '0;
      return;
    end
    sg = s.sca >> GL; wg = s.wra >> GL; lg = s.lra >> GL;
    fire = s.scv && (!m_rv || s.rdy);
`ifdef AXI_RISCV_RSV_STATS_EN
    if (m_rv && s.rdy) begin
      if (m_ok) begin if (m_okc != 32'hFFFF_FFFF) m_okc++; end
      else      begin if (m_failc != 32'hFFFF_FFFF) m_failc++; end
    end
`endif
    ok = 0;
    for (int i = 0; i < NR; i++)
      if (m_v[i] && m_id[i] == s.scid && m_g[i] == sg && in_range(s.sca)) ok = 1;
    for (int i = 0; i < NR; i++) begin
      nv[i] = m_v[i];
      if (s.wrv && m_g[i] == wg) nv[i] = 0;
      if (fire && m_id[i] == s.scid) nv[i] = 0;
      if (fire && ok && m_g[i] == sg) nv[i] = 0;
    end
    if (s.lrv && in_range(s.lra)) begin
      hit = 0;
      for (int i = 0; i < NR; i++)
        if (nv[i] && m_id[i] == s.lrid) begin hit = 1; m_g[i] = lg; end
      if (!hit) begin
        slot = -1;
        for (int i = NR - 1; i >= 0; i--) if (!nv[i]) slot = i;
        if (slot < 0) begin slot = m_ptr; m_ptr = (m_ptr + 1) % NR; end
        nv[slot] = 1; m_id[slot] = s.lrid; m_g[slot] = lg;
      end
    end
    for (int i = 0; i < NR; i++) m_v[i] = nv[i];
    if (fire) begin m_rv = 1; m_ok = ok; m_rid = s.scid; end
    else if (s.rdy) m_rv = 0;
  endtask

  // One clock: drive, check the ready path, advance model and DUT, compare.
  task automatic step(input stim_t s);
    rst_i = s.rst; lr_valid_i = s.lrv; lr_addr_i = s.lra; lr_id_i = s.lrid;
    sc_valid_i = s.scv; sc_addr_i = s.sca; sc_id_i = s.scid;
    sc_resp_ready_i = s.rdy; wr_valid_i = s.wrv; wr_addr_i = s.wra;
    #1;
    chk("sc_ready", 64'(sc_ready_o), 64'(!m_rv || s.rdy));
    chk("lr_ready", 64'(lr_ready_o), 64'd1);
    model_step(s);
    @(posedge clk_i); #1;
    chk("resp_valid", 64'(sc_resp_valid_o), 64'(m_rv));
    if (m_rv || s.rst) begin
      chk("resp_ok", 64'(sc_resp_ok_o), 64'(m_ok));
      chk("resp_id", 64'(sc_resp_id_o), 64'(m_rid));
    end
    chk("rsv_count", 64'(rsv_count_o), 64'(m_cnt()));
    chk("ok_cnt", 64'(sc_ok_cnt_o), 64'(m_okc));
    chk("fail_cnt", 64'(sc_fail_cnt_o), 64'(m_failc));
  endtask

  vec_t  vecs [15];
  stim_t idle, st;

  initial begin
    idle = S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[0]  = '{S(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0};
    vecs[1]  = '{S(0, 1, 64'h1000, 1, 0, 0, 0, 1, 0, 0), 0, 0, 1};
    vecs[2]  = '{S(0, 0, 0, 0, 1, 64'h1004, 1, 1, 0, 0), 1, 1, 0};
    vecs[3]  = '{idle, 0, 0, 0};
    vecs[4]  = '{S(0, 1, 64'h2000, 2, 0, 0, 0, 1, 0, 0), 0, 0, 1};
    vecs[5]  = '{S(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h2007), 0, 0, 0};
    vecs[6]  = '{S(0, 0, 0, 0, 1, 64'h2000, 2, 1, 0, 0), 1, 0, 0};
    vecs[7]  = '{S(0, 1, 64'h3000, 3, 0, 0, 0, 1, 1, 64'h3000), 0, 0, 1};
    vecs[8]  = '{S(0, 0, 0, 0, 1, 64'h3000, 3, 1, 0, 0), 1, 1, 0};
    vecs[9]  = '{S(0, 1, 64'h0000_7fff_ffff_fff8, 5, 0, 0, 0, 1, 0, 0), 0, 0, 1};
    vecs[10] = '{S(0, 0, 0, 0, 1, 64'h0000_8000_0000_0007, 5, 1, 0, 0), 1, 0, 0};
    vecs[11] = '{S(0, 1, 64'h0000_8000_0000_0000, 6, 0, 0, 0, 1, 0, 0), 0, 0, 0};
    vecs[12] = '{S(0, 1, 64'h6000, 9, 0, 0, 0, 1, 0, 0), 0, 0, 1};
    vecs[13] = '{S(0, 1, 64'h6000, 9, 1, 64'h6000, 9, 1, 0, 0), 1, 1, 1};
    vecs[14] = '{S(0, 0, 0, 0, 1, 64'h6008, 9, 1, 0, 0), 1, 0, 0};

    #1;
    // Directed vector table
    for (int k = 0; k < 15; k++) begin
      step(vecs[k].s);
      chk($sformatf("vec%0d_valid", k), 64'(sc_resp_valid_o), 64'(vecs[k].exp_rv));
      if (vecs[k].exp_rv) chk($sformatf("vec%0d_ok", k), 64'(sc_resp_ok_o), 64'(vecs[k].exp_ok));
      chk($sformatf("vec%0d_count", k), 64'(rsv_count_o), 64'(vecs[k].exp_cnt));
    end

    // Eviction: five IDs into four slots, slot 0 (id 0) is the first victim
    step(S(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++) begin
      step(S(0, 1, 64'h10000 + 64'(k) * 64'h100, k, 0, 0, 0, 1, 0, 0));
      chk("evict_count", 64'(rsv_count_o), 64'((k < 4) ? k + 1 : 4));
    end
    step(S(0, 0, 0, 0, 1, 64'h10000, 0, 1, 0, 0));
    chk("evict_sc0_ok", 64'(sc_resp_ok_o), 64'd0);
    step(S(0, 0, 0, 0, 1, 64'h10400, 4, 1, 0, 0));
    chk("evict_sc4_ok", 64'(sc_resp_ok_o), 64'd1);
    chk("evict_sc4_id", 64'(sc_resp_id_o), 64'd4);

    // Backpressure, then reset with a response pending
    step(S(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(S(0, 1, 64'h4000, 7, 0, 0, 0, 1, 0, 0));
    step(S(0, 0, 0, 0, 1, 64'h4000, 7, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      step(S(0, 0, 0, 0, 1, 64'h4000, 8, 0, 0, 0));
      chk("bp_ready_low", 64'(sc_ready_o), 64'd0);
      chk("bp_hold_valid", 64'(sc_resp_valid_o), 64'd1);
      chk("bp_hold_ok", 64'(sc_resp_ok_o), 64'd1);
      chk("bp_hold_id", 64'(sc_resp_id_o), 64'd7);
    end
    step(S(0, 1, 64'h4100, 3, 0, 0, 0, 0, 0, 0));
    step(S(1, 0, 0, 0, 1, 64'h4000, 8, 0, 0, 0));
    chk("rst_drop_valid", 64'(sc_resp_valid_o), 64'd0);
    chk("rst_count", 64'(rsv_count_o), 64'd0);

    // Randomized traffic on a small granule pool against the model
    for (int k = 0; k < 3000; k++) begin
      st.rst  = ($urandom_range(0, 199) == 0);
      st.lrv  = ($urandom_range(0, 2) == 0);
      st.lra  = ($urandom_range(0, 15) == 0) ? A_END + 64'($urandom_range(1, 64))
                : 64'h5000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      st.lrid = IW'($urandom_range(0, 5));
      st.scv  = ($urandom_range(0, 2) == 0);
      st.sca  = ($urandom_range(0, 15) == 0) ? A_END + 64'($urandom_range(1, 64))
                : 64'h5000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      st.scid = IW'($urandom_range(0, 5));
      st.rdy  = ($urandom_range(0, 3) != 0);
      st.wrv  = ($urandom_range(0, 4) == 0);
      st.wra  = 64'h5000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      step(st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
